// File: rtl/piece_controller_if.sv
// piece_controller_if: command/checker/state bundle between the piece controller and its neighbours
// master: drives spawn/piece_type/requests/collision, observes chk_* and cur_* state
// slave : the controller; consumes requests and the checker result, drives candidate and committed state
interface piece_controller_if;
  logic spawn;
  logic [2:0] piece_type;
  logic grav_tick;
  logic move_left;
  logic move_right;
  logic rotate;
  logic collision;
  logic [3:0] chk_x;
  logic [4:0] chk_y;
  logic [15:0] chk_float;
  logic [3:0] cur_x;
  logic [4:0] cur_y;
  logic [15:0] cur_float;
  logic [1:0] cur_rot;
  logic piece_active;
  logic lock_valid;
  logic game_over;
  logic busy;
  modport master (
    output spawn, piece_type, grav_tick, move_left, move_right, rotate, collision,
    input chk_x, chk_y, chk_float, cur_x, cur_y, cur_float, cur_rot, piece_active, lock_valid, game_over, busy
  );
  modport slave (
    input spawn, piece_type, grav_tick, move_left, move_right, rotate, collision,
    output chk_x, chk_y, chk_float, cur_x, cur_y, cur_float, cur_rot, piece_active, lock_valid, game_over, busy
  );
endinterface

// File: rtl/piece_controller.sv
// piece_controller: falling-piece state, candidate moves to the collision checker, commit/lock decisions
// clk, rst : clock and asynchronous active-high reset
// bus      : slave side of piece_controller_if (spawn/requests/collision in; chk_*, cur_*, status out)
module piece_controller (
  input logic clk,
  input logic rst,
  piece_controller_if.slave bus
);
  typedef enum logic [2:0] {EMPTY, READY, PROPOSE, EVAL, DEAD} state_t;
  typedef enum logic [2:0] {K_SPAWN, K_GRAV, K_ROT, K_LEFT, K_RIGHT} kind_t;
  state_t state, state_nx;
  kind_t kind, cand_kind;
  logic [3:0] pend, sel, clr;
  logic [2:0] ptype;
  logic [3:0] chk_x, cur_x, cand_x;
  logic [4:0] chk_y, cur_y, cand_y;
  logic [15:0] chk_float, cur_float, cand_float, rot_float;
  logic [1:0] chk_rot, cur_rot, cand_rot;
  logic piece_active, lock_valid, busy, game_over;
  logic spawn_ok, ready, ok_rot, ok_l, ok_r, fail, issue, load, lock;

  // Bit k of a pattern lives at vector index 15-k (MSB is cell 0).
  function automatic logic [15:0] shape0(input logic [2:0] t);
    return t == 3'd0 ? 16'h00F0 : t == 3'd1 ? 16'h0066 : t == 3'd2 ? 16'h00E4 :
           t == 3'd3 ? 16'h00C6 : t == 3'd4 ? 16'h006C : t == 3'd5 ? 16'h00E8 : 16'h00E2;
  endfunction

  // I turns in the full 4x4 box, the others in the 3x3 box at rows 1-3, O never changes.
  function automatic logic [15:0] rot_cw(input logic [2:0] t, input logic [15:0] p);
    logic [15:0] q;
    q = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (p[15-4*r-c]) begin
          if (t == 3'd0) q[15-4*(3-c)-r] = 1'b1;
          else if (r > 0 && c < 3) q[15-4*(3-c)-(r-1)] = 1'b1;
        end
    return t == 3'd1 ? shape0(3'd1) : q;
  endfunction

  function automatic logic [15:0] shape(input logic [2:0] t, input logic [1:0] rot);
    logic [15:0] p;
    p = shape0(t);
    for (int i = 0; i < 3; i++)
      if (2'(i) < rot) p = rot_cw(t, p);
    return p;
  endfunction

  // Occupied columns must land on x 0..9; evaluated on the untruncated signed anchor.
  function automatic logic wall_ok(input logic signed [5:0] ax, input logic [15:0] p);
    logic ok;
    logic signed [5:0] x;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      x = ax - 6'sd3 + 6'(c);
      if ((p[15-c] | p[11-c] | p[7-c] | p[3-c]) && (x < 6'sd0 || x > 6'sd9)) ok = 1'b0;
    end
    return ok;
  endfunction

  assign spawn_ok = bus.spawn && bus.piece_type != 3'd7;
  assign ready = state == READY;
  assign rot_float = shape(ptype, cur_rot + 2'd1);
  assign ok_rot = wall_ok($signed({2'b00, cur_x}), rot_float);
  assign ok_l = wall_ok($signed({2'b00, cur_x}) - 6'sd1, cur_float);
  assign ok_r = wall_ok($signed({2'b00, cur_x}) + 6'sd1, cur_float);
  assign sel = pend[3] ? 4'b1000 : pend[2] ? 4'b0100 : pend[1] ? 4'b0010 : pend[0] ? 4'b0001 : 4'b0000;
  assign clr = ready ? sel : 4'b0000;
  assign fail = ready && ((sel[2] && !ok_rot) || (sel[1] && !ok_l) || (sel[0] && !ok_r));
  assign issue = ready && |pend && !fail;
  assign load = (state == EMPTY && spawn_ok) || issue;
  assign lock = state == EVAL && bus.collision && kind == K_GRAV;
  assign cand_x = sel[1] ? cur_x - 4'd1 : sel[0] ? cur_x + 4'd1 : cur_x;
  assign cand_y = sel[3] ? cur_y - 5'd1 : cur_y;
  assign cand_float = sel[2] ? rot_float : cur_float;
  assign cand_rot = sel[2] ? cur_rot + 2'd1 : cur_rot;
  assign cand_kind = sel[3] ? K_GRAV : sel[2] ? K_ROT : sel[1] ? K_LEFT : K_RIGHT;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= state_nx;

  always_comb begin
    state_nx = state == EMPTY ? (spawn_ok ? PROPOSE : EMPTY) :
               state == READY ? (issue ? PROPOSE : READY) :
               state == PROPOSE ? EVAL :
               state == EVAL ? (!bus.collision ? READY : kind == K_SPAWN ? DEAD : kind == K_GRAV ? EMPTY : READY) :
               DEAD;
  end

  always_comb begin
    busy = !(state == READY || state == EMPTY);
    game_over = state == DEAD;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= '0;
      kind <= K_SPAWN;
      ptype <= '0;
      chk_x <= '0;
      chk_y <= '0;
      chk_float <= '0;
      chk_rot <= '0;
      cur_x <= '0;
      cur_y <= '0;
      cur_float <= '0;
      cur_rot <= '0;
      piece_active <= 1'b0;
      lock_valid <= 1'b0;
    end else begin
      lock_valid <= lock;
      pend <= (lock || !piece_active) ? 4'b0000 :
              (pend & ~clr) | {bus.grav_tick, bus.rotate, bus.move_left, bus.move_right};
      if (load) begin
        chk_x <= issue ? cand_x : 4'd6;
        chk_y <= issue ? cand_y : 5'd19;
        chk_float <= issue ? cand_float : shape0(bus.piece_type);
        chk_rot <= issue ? cand_rot : 2'd0;
        kind <= issue ? cand_kind : K_SPAWN;
      end
      if (state == EMPTY && spawn_ok) ptype <= bus.piece_type;
      if (state == EVAL && !bus.collision) begin
        cur_x <= chk_x;
        cur_y <= chk_y;
        cur_float <= chk_float;
        cur_rot <= chk_rot;
        if (kind == K_SPAWN) piece_active <= 1'b1;
      end
      if (lock) piece_active <= 1'b0;
    end

  assign bus.chk_x = chk_x;
  assign bus.chk_y = chk_y;
  assign bus.chk_float = chk_float;
  assign bus.cur_x = cur_x;
  assign bus.cur_y = cur_y;
  assign bus.cur_float = cur_float;
  assign bus.cur_rot = cur_rot;
  assign bus.piece_active = piece_active;
  assign bus.lock_valid = lock_valid;
  assign bus.game_over = game_over;
  assign bus.busy = busy;
endmodule

// File: tb/tb_piece_controller.sv
// tb_piece_controller: table-driven moves plus scoreboarded candidates for piece_controller
module tb_piece_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piece_controller_if bus();
  piece_controller dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0] x;
    logic [4:0] y;
    logic [15:0] f;
  } cand_t;

  typedef struct {
    int k;
    logic col;
    logic prop;
    logic [3:0] px;
    logic [4:0] py;
    logic [15:0] pf;
    logic [3:0] cx;
    logic [4:0] cy;
    logic [15:0] cf;
    logic [1:0] cr;
  } vec_t;

  cand_t q[$];
  cand_t e_m;
  vec_t v[12];
  int total = 0;
  int bad = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // k: 0 grav, 1 rotate, 2 left, 3 right, 4 spawn
  task automatic pulse(input int k);
    bus.grav_tick = k == 0;
    bus.rotate = k == 1;
    bus.move_left = k == 2;
    bus.move_right = k == 3;
    bus.spawn = k == 4;
    tick(1);
    {bus.grav_tick, bus.rotate, bus.move_left, bus.move_right, bus.spawn} = '0;
  endtask

  // Every PROPOSE entry (busy rising) must match the oldest expected candidate.
  always @(negedge clk) begin
    if (rst) prev_busy = 1'b0;
    else begin
      if (bus.busy && !prev_busy) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_propose: got chk=(%0d,%0d,%h) expected none", bus.chk_x, bus.chk_y, bus.chk_float);
        end else begin
          e_m = q.pop_front();
          chk("sb_chk_x", bus.chk_x, e_m.x);
          chk("sb_chk_y", bus.chk_y, e_m.y);
          chk("sb_chk_float", bus.chk_float, e_m.f);
        end
      end
      prev_busy = bus.busy;
    end
  end

  initial begin
    {bus.grav_tick, bus.rotate, bus.move_left, bus.move_right, bus.spawn, bus.collision} = '0;
    bus.piece_type = 3'd0;
    v[0]  = '{2, 1'b0, 1'b1, 4'd5, 5'd19, 16'h00E4, 4'd5, 5'd19, 16'h00E4, 2'd0};
    v[1]  = '{2, 1'b0, 1'b1, 4'd4, 5'd19, 16'h00E4, 4'd4, 5'd19, 16'h00E4, 2'd0};
    v[2]  = '{2, 1'b0, 1'b1, 4'd3, 5'd19, 16'h00E4, 4'd3, 5'd19, 16'h00E4, 2'd0};
    v[3]  = '{2, 1'b0, 1'b0, 4'd0, 5'd0,  16'h0000, 4'd3, 5'd19, 16'h00E4, 2'd0};
    v[4]  = '{1, 1'b0, 1'b1, 4'd3, 5'd19, 16'h0464, 4'd3, 5'd19, 16'h0464, 2'd1};
    v[5]  = '{2, 1'b0, 1'b1, 4'd2, 5'd19, 16'h0464, 4'd2, 5'd19, 16'h0464, 2'd1};
    v[6]  = '{1, 1'b0, 1'b0, 4'd0, 5'd0,  16'h0000, 4'd2, 5'd19, 16'h0464, 2'd1};
    v[7]  = '{3, 1'b1, 1'b1, 4'd3, 5'd19, 16'h0464, 4'd2, 5'd19, 16'h0464, 2'd1};
    v[8]  = '{3, 1'b0, 1'b1, 4'd3, 5'd19, 16'h0464, 4'd3, 5'd19, 16'h0464, 2'd1};
    v[9]  = '{0, 1'b0, 1'b1, 4'd3, 5'd18, 16'h0464, 4'd3, 5'd18, 16'h0464, 2'd1};
    v[10] = '{1, 1'b0, 1'b1, 4'd3, 5'd18, 16'h04E0, 4'd3, 5'd18, 16'h04E0, 2'd2};
    v[11] = '{3, 1'b0, 1'b1, 4'd4, 5'd18, 16'h04E0, 4'd4, 5'd18, 16'h04E0, 2'd2};

    tick(2);
    chk("rst_cur_x", bus.cur_x, 0);
    chk("rst_chk_float", bus.chk_float, 0);
    chk("rst_piece_active", bus.piece_active, 0);
    chk("rst_lock_valid", bus.lock_valid, 0);
    chk("rst_game_over", bus.game_over, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    tick(1);

    bus.piece_type = 3'd7;
    pulse(4);
    tick(2);
    chk("inv_spawn_busy", bus.busy, 0);
    chk("inv_spawn_chk_float", bus.chk_float, 0);

    bus.piece_type = 3'd2;
    q.push_back('{4'd6, 5'd19, 16'h00E4});
    pulse(4);
    chk("spawn_chk_x", bus.chk_x, 6);
    chk("spawn_chk_y", bus.chk_y, 19);
    chk("spawn_chk_float", bus.chk_float, 16'h00E4);
    chk("spawn_busy", bus.busy, 1);
    tick(1);
    chk("spawn_hold_x", bus.chk_x, 6);
    chk("spawn_hold_y", bus.chk_y, 19);
    chk("spawn_hold_float", bus.chk_float, 16'h00E4);
    tick(1);
    chk("spawn_cur_x", bus.cur_x, 6);
    chk("spawn_cur_y", bus.cur_y, 19);
    chk("spawn_cur_float", bus.cur_float, 16'h00E4);
    chk("spawn_cur_rot", bus.cur_rot, 0);
    chk("spawn_active", bus.piece_active, 1);

    for (int i = 0; i < 12; i++) begin
      bus.collision = v[i].col;
      if (v[i].prop) q.push_back('{v[i].px, v[i].py, v[i].pf});
      pulse(v[i].k);
      tick(3);
      chk($sformatf("v%0d_cur_x", i), bus.cur_x, v[i].cx);
      chk($sformatf("v%0d_cur_y", i), bus.cur_y, v[i].cy);
      chk($sformatf("v%0d_cur_float", i), bus.cur_float, v[i].cf);
      chk($sformatf("v%0d_cur_rot", i), bus.cur_rot, v[i].cr);
      chk($sformatf("v%0d_busy", i), bus.busy, 0);
    end
    bus.collision = 1'b0;

    q.push_back('{4'd4, 5'd17, 16'h04E0});
    q.push_back('{4'd3, 5'd17, 16'h04E0});
    bus.grav_tick = 1'b1;
    bus.move_left = 1'b1;
    tick(1);
    {bus.grav_tick, bus.move_left} = '0;
    tick(1);
    chk("prio_first_y", bus.chk_y, 17);
    chk("prio_first_x", bus.chk_x, 4);
    tick(6);
    chk("prio_cur_x", bus.cur_x, 3);
    chk("prio_cur_y", bus.cur_y, 17);

    for (int y = 16; y >= 1; y--) begin
      q.push_back('{4'd3, 5'(y), 16'h04E0});
      pulse(0);
      tick(3);
    end
    chk("floor_cur_y", bus.cur_y, 1);
    bus.collision = 1'b1;
    q.push_back('{4'd3, 5'd0, 16'h04E0});
    pulse(0);
    tick(1);
    chk("floor_chk_y", bus.chk_y, 0);
    tick(1);
    bus.piece_type = 3'd0;
    bus.spawn = 1'b1;
    tick(1);
    bus.spawn = 1'b0;
    chk("lock_valid_hi", bus.lock_valid, 1);
    chk("lock_cur_y", bus.cur_y, 1);
    chk("lock_active", bus.piece_active, 0);
    tick(1);
    chk("lock_valid_lo", bus.lock_valid, 0);
    chk("lock_spawn_ignored", bus.busy, 0);
    bus.collision = 1'b0;
    pulse(0);
    tick(3);
    chk("empty_grav_busy", bus.busy, 0);
    chk("empty_grav_chk_y", bus.chk_y, 0);

    q.push_back('{4'd6, 5'd19, 16'h00F0});
    pulse(4);
    tick(2);
    chk("i_spawn_float", bus.cur_float, 16'h00F0);
    for (int y = 18; y >= 0; y--) begin
      q.push_back('{4'd6, 5'(y), 16'h00F0});
      pulse(0);
      tick(3);
    end
    chk("i_bottom_y", bus.cur_y, 0);
    bus.collision = 1'b1;
    q.push_back('{4'd6, 5'd31, 16'h00F0});
    pulse(0);
    tick(1);
    chk("wrap_chk_y", bus.chk_y, 31);
    tick(2);
    chk("wrap_lock", bus.lock_valid, 1);
    chk("wrap_cur_y", bus.cur_y, 0);

    bus.collision = 1'b0;
    bus.piece_type = 3'd6;
    q.push_back('{4'd6, 5'd19, 16'h00E2});
    pulse(4);
    tick(1);
    rst = 1'b1;
    #1;
    chk("mid_rst_chk_x", bus.chk_x, 0);
    chk("mid_rst_chk_y", bus.chk_y, 0);
    chk("mid_rst_chk_float", bus.chk_float, 0);
    chk("mid_rst_cur_x", bus.cur_x, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_lock", bus.lock_valid, 0);
    tick(1);
    rst = 1'b0;
    pulse(0);
    tick(3);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_active", bus.piece_active, 0);
    chk("post_rst_lock", bus.lock_valid, 0);

    bus.collision = 1'b1;
    bus.piece_type = 3'd1;
    q.push_back('{4'd6, 5'd19, 16'h0066});
    pulse(4);
    tick(2);
    chk("dead_game_over", bus.game_over, 1);
    chk("dead_active", bus.piece_active, 0);
    bus.collision = 1'b0;
    bus.piece_type = 3'd2;
    pulse(4);
    tick(3);
    chk("dead_spawn_float", bus.chk_float, 16'h0066);
    chk("dead_sticky", bus.game_over, 1);
    rst = 1'b1;
    tick(1);
    chk("dead_rst_game_over", bus.game_over, 0);
    rst = 1'b0;
    tick(1);

    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
